// File: rtl/affine_sched_ctrl.sv
// affine_sched_ctrl: programmable affine loop-nest schedule; first valid offset+1 cycles after start, no backpressure.
// Optional AFFINE_SCHED_REPEAT_EN adds a repeat count R at cfg address 2*DIMS+1 (R+1 back-to-back passes).
module affine_sched_ctrl #(
    parameter int DIMS  = 3,
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                cfg_we,
    input  logic [7:0]          cfg_addr,
    input  logic [CNT_W-1:0]    cfg_wdata,
    input  logic                start,
    output logic [DIMS*W-1:0]   d,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);
    localparam int PW = CNT_W + W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_offset;
    logic [DIMS-1:0][W-1:0]     r_ext;
    logic [DIMS-1:0][CNT_W-1:0] r_stride;
    logic [DIMS-1:0][W-1:0]     r_a_ext;
    logic [DIMS-1:0][CNT_W-1:0] r_a_stride;
    logic [DIMS-1:0][W-1:0]     r_d;
    logic [DIMS-1:0][CNT_W-1:0] r_t;
    logic [CNT_W-1:0]           r_dly;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_cfg_err;

    logic                       w_illegal;
    logic [DIMS-1:0]            w_fire;
    logic [DIMS-1:0]            w_at_ext;
    logic [DIMS-1:0]            w_sel;
    logic [DIMS-1:0]            w_clr;
    logic                       w_all_ext;
    logic                       w_adv;
    logic                       w_rep_pend;
    logic                       w_rep_go;

`ifdef AFFINE_SCHED_REPEAT_EN
    logic [CNT_W-1:0]           r_rep;
    logic [CNT_W-1:0]           r_rep_left;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset <= '0;
            r_ext    <= '0;
            for (int k = 0; k < DIMS; k++) r_stride[k] <= CNT_W'(1);
`ifdef AFFINE_SCHED_REPEAT_EN
            r_rep    <= '0;
`endif
        end else if (cfg_we && !flush && r_state == S_IDLE) begin
            if (cfg_addr == 8'd0) r_offset <= cfg_wdata;
            for (int k = 0; k < DIMS; k++) begin
                if (cfg_addr == 8'(k + 1))        r_ext[k]    <= cfg_wdata[W-1:0];
                if (cfg_addr == 8'(DIMS + k + 1)) r_stride[k] <= cfg_wdata;
            end
`ifdef AFFINE_SCHED_REPEAT_EN
            if (cfg_addr == 8'(2 * DIMS + 1)) r_rep <= cfg_wdata;
`endif
        end
    end

    // Each outer stride must cover the full span of the next-inner loop, else tuples would collide.
    always_comb begin
        w_illegal = 1'b0;
        for (int k = 0; k < DIMS; k++) begin
            if (r_stride[k] == '0) w_illegal = 1'b1;
        end
        for (int k = 0; k < DIMS - 1; k++) begin
            if (PW'(r_stride[k]) < PW'(r_stride[k+1]) * (PW'(r_ext[k+1]) + PW'(1))) w_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cfg_err <= 1'b0;
        else        r_cfg_err <= w_illegal;
    end

    // The deepest dimension whose timer expires below its extent advances; deeper ones restart.
    always_comb begin
        logic found;
        logic seen;
        found    = 1'b0;
        seen     = 1'b0;
        w_fire   = '0;
        w_at_ext = '0;
        w_sel    = '0;
        w_clr    = '0;
        for (int k = 0; k < DIMS; k++) begin
            w_fire[k]   = (r_t[k] == r_a_stride[k] - CNT_W'(1));
            w_at_ext[k] = (r_d[k] == r_a_ext[k]);
        end
        for (int k = DIMS - 1; k >= 0; k--) begin
            if (!found && w_fire[k] && !w_at_ext[k]) begin
                w_sel[k] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int k = 0; k < DIMS; k++) begin
            w_clr[k] = seen;
            if (w_sel[k]) seen = 1'b1;
        end
    end

    assign w_all_ext = &w_at_ext;
    assign w_adv     = |w_sel;
`ifdef AFFINE_SCHED_REPEAT_EN
    assign w_rep_pend = w_all_ext && (r_rep_left != '0);
`else
    assign w_rep_pend = 1'b0;
`endif
    assign w_rep_go  = w_rep_pend && w_fire[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_ext    <= '0;
            for (int k = 0; k < DIMS; k++) r_a_stride[k] <= CNT_W'(1);
            r_d        <= '0;
            r_t        <= '0;
            r_dly      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef AFFINE_SCHED_REPEAT_EN
            r_rep_left <= '0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    if (start && !r_cfg_err) begin
                        // Snapshot so a config write in the start cycle only affects later runs.
                        r_a_ext    <= r_ext;
                        r_a_stride <= r_stride;
`ifdef AFFINE_SCHED_REPEAT_EN
                        r_rep_left <= r_rep;
`endif
                        r_busy     <= 1'b1;
                        if (r_offset == '0) begin
                            r_state <= S_RUN;
                            r_valid <= 1'b1;
                            r_d     <= '0;
                            r_t     <= '0;
                        end else begin
                            r_state <= S_DELAY;
                            r_dly   <= r_offset;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_dly == CNT_W'(1)) begin
                        r_state <= S_RUN;
                        r_valid <= 1'b1;
                        r_d     <= '0;
                        r_t     <= '0;
                    end else begin
                        r_dly <= r_dly - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_all_ext && !w_rep_pend) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_rep_go) begin
`ifdef AFFINE_SCHED_REPEAT_EN
                        r_rep_left <= r_rep_left - CNT_W'(1);
`endif
                        r_d     <= '0;
                        r_t     <= '0;
                        r_valid <= 1'b1;
                    end else begin
                        r_valid <= w_adv;
                        for (int k = 0; k < DIMS; k++) begin
                            if (w_sel[k]) begin
                                r_d[k] <= r_d[k] + W'(1);
                                r_t[k] <= '0;
                            end else if (w_clr[k]) begin
                                r_d[k] <= '0;
                                r_t[k] <= '0;
                            end else begin
                                r_t[k] <= r_t[k] + CNT_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign d       = r_d;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_affine_sched_ctrl.sv
// Bench for affine_sched_ctrl: directed and random configs against an enumerated-schedule reference.
module tb_affine_sched_ctrl;
    localparam int DIMS  = 3;
    localparam int W     = 16;
    localparam int CNT_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                cfg_we;
    logic [7:0]          cfg_addr;
    logic [CNT_W-1:0]    cfg_wdata;
    logic                start;
    logic [DIMS*W-1:0]   d;
    logic                valid;
    logic                busy;
    logic                done;
    logic                cfg_err;

    always #5 clk = ~clk;

    affine_sched_ctrl #(.DIMS(DIMS), .W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .d(d), .valid(valid), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference config as seen by the bench
    longint m_off, m_rep;
    longint m_ext[3];
    longint m_str[3];

    longint      exp_cyc[$];
    logic [47:0] exp_d[$];
    longint      exp_done;
    longint      obs_cyc[$];
    logic [47:0] obs_d[$];
    int          obs_done_cyc, obs_done_cnt, obs_busy_fall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_default();
        m_off = 0; m_rep = 0;
        for (int k = 0; k < 3; k++) begin m_ext[k] = 0; m_str[k] = 1; end
    endtask

    function automatic bit model_legal();
        if (m_str[0] == 0 || m_str[1] == 0 || m_str[2] == 0) return 1'b0;
        if (m_str[0] < m_str[1] * (m_ext[1] + 1)) return 1'b0;
        if (m_str[1] < m_str[2] * (m_ext[2] + 1)) return 1'b0;
        return 1'b1;
    endfunction

    // Every tuple fires at offset+1 + pass*span + sum(stride*index), listed in nest order.
    task automatic build_model();
        longint c;
        logic [47:0] t;
        exp_cyc.delete();
        exp_d.delete();
        for (longint p = 0; p <= m_rep; p++)
            for (longint a = 0; a <= m_ext[0]; a++)
                for (longint b = 0; b <= m_ext[1]; b++)
                    for (longint e = 0; e <= m_ext[2]; e++) begin
                        c = m_off + 1 + p * m_str[0] * (m_ext[0] + 1) + a * m_str[0] + b * m_str[1] + e * m_str[2];
                        t = {16'(e), 16'(b), 16'(a)};
                        exp_cyc.push_back(c);
                        exp_d.push_back(t);
                    end
        exp_done = exp_cyc[exp_cyc.size() - 1] + 1;
    endtask

    task automatic cfg_write(input int addr, input longint val);
        cfg_we = 1'b1; cfg_addr = 8'(addr); cfg_wdata = CNT_W'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr == 0) m_off = val;
        else if (addr >= 1 && addr <= 3) m_ext[addr-1] = val & 64'hFFFF;
        else if (addr >= 4 && addr <= 6) m_str[addr-4] = val;
`ifdef AFFINE_SCHED_REPEAT_EN
        else if (addr == 7) m_rep = val;
`endif
    endtask

    task automatic set_cfg(input longint off, input longint e0, input longint e1, input longint e2,
                           input longint s0, input longint s1, input longint s2);
        cfg_write(0, off);
        cfg_write(1, e0); cfg_write(2, e1); cfg_write(3, e2);
        cfg_write(4, s0); cfg_write(5, s1); cfg_write(6, s2);
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge in cycle T; raises start and records outputs for cycles T+1..
    task automatic run_sched(input int max_cyc, input int flush_at, input int cfgw_at);
        bit was_busy;
        was_busy = 1'b0;
        obs_cyc.delete(); obs_d.delete();
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_fall = -1;
        start = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (valid) begin obs_cyc.push_back(i); obs_d.push_back(d); end
            if (done) begin obs_done_cnt++; if (obs_done_cyc < 0) obs_done_cyc = i; end
            if (busy) was_busy = 1'b1;
            else if (was_busy && obs_busy_fall < 0) obs_busy_fall = i;
            if (i == flush_at + 1) begin
                check("flush_valid", 64'(valid), 64'd0);
                check("flush_d", 64'(d), 64'd0);
                check("flush_busy", 64'(busy), 64'd0);
            end
            start  = 1'b0;
            flush  = (i == flush_at);
            cfg_we = (i == cfgw_at);
            if (i == cfgw_at) begin cfg_addr = 8'd0; cfg_wdata = '0; end
            if (obs_done_cyc >= 0 && i >= obs_done_cyc + 3) break;
        end
        flush = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare_sched(input string tag);
        int n;
        check($sformatf("%s_count", tag), 64'(obs_cyc.size()), 64'(exp_cyc.size()));
        n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 64'(obs_cyc[i]), 64'(exp_cyc[i]));
            check($sformatf("%s_d%0d", tag, i), 64'(obs_d[i]), 64'(exp_d[i]));
        end
        check($sformatf("%s_done_cyc", tag), 64'(obs_done_cyc), 64'(exp_done));
        check($sformatf("%s_done_cnt", tag), 64'(obs_done_cnt), 64'd1);
        check($sformatf("%s_busy_fall", tag), 64'(obs_busy_fall), 64'(exp_done));
    endtask

    initial begin
        int np;
        int stray;
        longint e0, e1, e2, s0, s1, s2, off;
        bit want_legal;

        rst_n = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        model_default();
        repeat (3) @(negedge clk);
        check("rst_d", 64'(d), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_cfg_err", 64'(cfg_err), 64'd0);

        // Default config: single valid at T+1, done at T+2
        build_model();
        run_sched(10, -5, -5);
        compare_sched("default");

        // Dense 64x64 nest behind a 414-cycle offset
        set_cfg(414, 0, 63, 63, 4096, 64, 1);
        check("t2_cfg_err", 64'(cfg_err), 64'd0);
        build_model();
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("t2");
        check("t2_first_cyc", 64'(obs_cyc[0]), 64'd415);
        check("t2_last_cyc", 64'(obs_cyc[obs_cyc.size()-1]), 64'd4510);

        // Sparse nest with 1- and 2-cycle gaps
        set_cfg(0, 0, 3, 3, 64, 8, 2);
        build_model();
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("t3");
        check("t3_fifth_cyc", 64'(obs_cyc[4]), 64'd9);

        // Overlapping strides are refused
        cfg_write(6, 1); cfg_write(5, 3);
        repeat (2) @(negedge clk);
        check("t4_model_legal", 64'(model_legal()), 64'd0);
        check("t4_cfg_err", 64'(cfg_err), 64'd1);
        stray = 0;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || valid || done) stray++;
        end
        check("t4_start_refused", 64'(stray), 64'd0);
        cfg_write(5, 4);
        repeat (2) @(negedge clk);
        check("t4_cfg_err_clear", 64'(cfg_err), 64'd0);

        // Flush mid-run, with an ignored config write during RUN, then an identical restart
        set_cfg(414, 0, 63, 63, 4096, 64, 1);
        build_model();
        run_sched(1010, 1000, 500);
        np = 0;
        foreach (exp_cyc[i]) if (exp_cyc[i] <= 1000) np++;
        check("t5_prefix_count", 64'(obs_cyc.size()), 64'(np));
        for (int i = 0; i < np && i < obs_cyc.size(); i++) begin
            check($sformatf("t5_prefix_cyc%0d", i), 64'(obs_cyc[i]), 64'(exp_cyc[i]));
            check($sformatf("t5_prefix_d%0d", i), 64'(obs_d[i]), 64'(exp_d[i]));
        end
        check("t5_no_done", 64'(obs_done_cnt), 64'd0);
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("t5_restart");

        // Write in the start cycle lands but does not affect the run it starts with
        set_cfg(0, 0, 3, 3, 64, 8, 2);
        build_model();
        cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 32'd5;
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("same_cyc_old");
        m_off = 5;
        build_model();
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("same_cyc_new");

        // Random configurations, some deliberately illegal
        for (int it = 0; it < 8; it++) begin
            want_legal = (it % 3) != 2;
            e2  = $urandom_range(0, 3);
            s2  = $urandom_range(1, 3);
            e1  = $urandom_range(0, 3);
            s1  = want_legal ? s2 * (e2 + 1) + $urandom_range(0, 2) : s2 * (e2 + 1) - 1;
            e0  = $urandom_range(0, 2);
            s0  = s1 * (e1 + 1) + $urandom_range(0, 3);
            off = $urandom_range(0, 20);
            set_cfg(off, e0, e1, e2, s0, s1, s2);
            check($sformatf("rnd%0d_cfg_err", it), 64'(cfg_err), 64'(!model_legal()));
            if (model_legal()) begin
                build_model();
                run_sched(int'(exp_done) + 10, -5, -5);
                compare_sched($sformatf("rnd%0d", it));
            end else begin
                stray = 0;
                start = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    start = 1'b0;
                    if (busy || valid || done) stray++;
                end
                check($sformatf("rnd%0d_refused", it), 64'(stray), 64'd0);
            end
        end

`ifdef AFFINE_SCHED_REPEAT_EN
        set_cfg(0, 0, 3, 3, 64, 8, 2);
        cfg_write(7, 1);
        build_model();
        run_sched(int'(exp_done) + 10, -5, -5);
        compare_sched("repeat");
        check("repeat_pass2_first", 64'(obs_cyc[16]), 64'd65);
        cfg_write(7, 0);
`endif

        // Asynchronous reset mid-run restores all outputs and config
        set_cfg(414, 0, 63, 63, 4096, 64, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("midrun_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_d", 64'(d), 64'd0);
        check("midrun_rst_valid", 64'(valid), 64'd0);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_default();
        repeat (2) @(negedge clk);
        build_model();
        run_sched(10, -5, -5);
        compare_sched("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
